// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit: one 1-bit step per clock.
// Reports completion with a one-cycle done pulse; result held until next start.
module shift_sequencer #(
  parameter int N  = 32,
  parameter int SW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          flush_i,
  input  logic [1:0]    op_i,
  input  logic [N-1:0]  a_i,
  input  logic [SW-1:0] shamt_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [N-1:0]  result_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [N-1:0]  result_q, result_d;

  logic          accept;
  logic          last;
  logic          zero_sh;
  logic [N-1:0]  step;

  // start is only taken outside SHIFT; flush wins over start
  assign accept  = start_i & ~flush_i
                 & (state_q != S_SHIFT);
  assign last    = (cnt_q == SW'(1));
  assign zero_sh = (shamt_i == '0);

  always_comb begin
    step = {acc_q[N-2:0], 1'b0};
    unique case (op_q)
      2'b01:   step = {1'b0, acc_q[N-1:1]};
      2'b10:   step = {acc_q[N-1], acc_q[N-1:1]};
      default: step = {acc_q[N-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else if (accept) begin
      state_d = zero_sh ? S_DONE : S_SHIFT;
    end else begin
      unique case (state_q)
        S_SHIFT: if (last) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    if (!flush_i) begin
      if (accept) begin
        acc_d = a_i;
        cnt_d = shamt_i;
        op_d  = op_i;
        if (zero_sh) result_d = a_i;
      end else if (state_q == S_SHIFT) begin
        acc_d = step;
        cnt_d = cnt_q - SW'(1);
        if (last) result_d = step;
      end
    end
  end

  always_comb begin
    busy_o   = (state_q == S_SHIFT);
    done_o   = (state_q == S_DONE);
    result_o = result_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed scenarios plus random traffic
// checked every cycle against a timestamp-based transaction model.
module tb_shift_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        flush_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [4:0]  shamt_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  shift_sequencer #(.N(32), .SW(5)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .shamt_i  (shamt_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // model: an op accepted in cycle acc_c finishes in cycle done_c
  bit          m_act  = 1'b0;
  int          m_acc  = 0;
  int          m_done = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_res  = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_shift(
    input logic [1:0] op,
    input logic [31:0] a,
    input int s);
    case (op)
      2'b01:   return a >> s;
      2'b10:   return $unsigned($signed(a) >>> s);
      default: return a << s;
    endcase
  endfunction

  function automatic bit m_busy(input int k);
    return m_act && k > m_acc && k < m_done;
  endfunction

  function automatic bit m_dn(input int k);
    return m_act && k == m_done;
  endfunction

  task automatic model_reset();
    m_act = 1'b0;
    m_res = '0;
  endtask

  task automatic model_edge();
    bit bz;
    if (rst_i) begin
      model_reset();
    end else begin
      bz = m_busy(cyc);
      if (flush_i) begin
        m_act = 1'b0;
      end else if (start_i && !bz) begin
        m_act  = 1'b1;
        m_acc  = cyc;
        m_done = cyc + 1 + int'(shamt_i);
        m_pend = ref_shift(op_i, a_i,
                           int'(shamt_i));
      end else if (m_act && cyc >= m_done) begin
        m_act = 1'b0;
      end
      if (m_act && m_done == cyc + 1)
        m_res = m_pend;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    cyc++;
    @(negedge clk_i);
    chk("busy", 32'(busy_o), 32'(m_busy(cyc)));
    chk("done", 32'(done_o), 32'(m_dn(cyc)));
    chk("result", result_o, m_res);
  endtask

  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input int sh,
                        output int lat,
                        output int bc);
    int c;
    bit found;
    c       = cyc;
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    shamt_i = 5'(sh);
    tick();
    start_i = 1'b0;
    bc      = 0;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (done_o) found = 1'b1;
      else begin
        if (busy_o) bc++;
        tick();
      end
    end
    lat = found ? cyc - c : -1;
    if (!found) chk("timeout", 32'(lat), 32'(1 + sh));
  endtask

  int lat, bc, c0, ndone;

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 2'b00;
    a_i     = '0;
    shamt_i = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_res", result_o, 32'd0);
    rst_i = 1'b0;
    tick();

    run_op(2'b00, 32'h1, 31, lat, bc);
    chk("sll31_lat", 32'(lat), 32'd32);
    chk("sll31_busy", 32'(bc), 32'd31);
    chk("sll31_res", result_o, 32'h8000_0000);
    tick();

    run_op(2'b01, 32'h8000_00F0, 4, lat, bc);
    chk("srl_lat", 32'(lat), 32'd5);
    chk("srl_res", result_o, 32'h0800_000F);
    tick();
    run_op(2'b10, 32'h8000_00F0, 4, lat, bc);
    chk("sra_lat", 32'(lat), 32'd5);
    chk("sra_res", result_o, 32'hF800_000F);
    tick();
    run_op(2'b11, 32'h1, 4, lat, bc);
    chk("op11_res", result_o, 32'h0000_0010);
    tick();

    run_op(2'b10, 32'hDEAD_BEEF, 0, lat, bc);
    chk("z_lat", 32'(lat), 32'd1);
    chk("z_busy", 32'(bc), 32'd0);
    chk("z_res", result_o, 32'hDEAD_BEEF);
    run_op(2'b00, 32'h1, 3, lat, bc);
    chk("b2b_lat", 32'(lat), 32'd4);
    chk("b2b_res", result_o, 32'h0000_0008);
    tick();

    c0      = cyc;
    start_i = 1'b1;
    op_i    = 2'b00;
    a_i     = 32'h1;
    shamt_i = 5'd8;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    start_i = 1'b1;
    a_i     = 32'hFFFF_FFFF;
    shamt_i = 5'd1;
    tick();
    start_i = 1'b0;
    ndone   = 0;
    lat     = -1;
    for (int i = 0; i < 12; i++) begin
      if (done_o) begin
        ndone++;
        lat = cyc - c0;
        chk("ign_res", result_o, 32'h0000_0100);
      end
      tick();
    end
    chk("ign_lat", 32'(lat), 32'd9);
    chk("ign_ndone", 32'(ndone), 32'd1);

    run_op(2'b00, 32'h1234_5678, 0, lat, bc);
    tick();
    tick();
    c0      = cyc;
    start_i = 1'b1;
    op_i    = 2'b00;
    a_i     = 32'h1;
    shamt_i = 5'd10;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    flush_i = 1'b1;
    start_i = 1'b1;
    a_i     = 32'h5;
    shamt_i = 5'd2;
    tick();
    flush_i = 1'b0;
    start_i = 1'b0;
    chk("fl_cyc", 32'(cyc - c0), 32'd5);
    chk("fl_busy", 32'(busy_o), 32'd0);
    chk("fl_res", result_o, 32'h1234_5678);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o) ndone++;
      tick();
    end
    chk("fl_ndone", 32'(ndone), 32'd0);
    chk("fl_hold", result_o, 32'h1234_5678);

    start_i = 1'b1;
    op_i    = 2'b00;
    a_i     = 32'h5;
    shamt_i = 5'd20;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    chk("ar_pre", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("ar_busy", 32'(busy_o), 32'd0);
    chk("ar_done", 32'(done_o), 32'd0);
    chk("ar_res", result_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    run_op(2'b00, 32'h3, 2, lat, bc);
    chk("ar_lat", 32'(lat), 32'd3);
    chk("ar_new", result_o, 32'h0000_000C);
    tick();

    for (int i = 0; i < 1500; i++) begin
      start_i = ($urandom_range(0, 99) < 35);
      flush_i = ($urandom_range(0, 99) < 4);
      rst_i   = ($urandom_range(0, 199) == 0);
      op_i    = 2'($urandom_range(0, 3));
      a_i     = $urandom;
      shamt_i = ($urandom_range(0, 3) == 0)
              ? 5'd0 : 5'($urandom_range(0, 31));
      tick();
    end
    start_i = 1'b0;
    flush_i = 1'b0;
    rst_i   = 1'b0;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
